dram_axi_bridge: RTL and testbench

Parametrised successor to the single-beat MemoryBus-to-AXI3 DRAM adapter. Accepts MemoryBus requests, holds them in a one-entry issue register, drives the AXI3 AW/W/AR channels with independently handshaken valids, and tracks outstanding reads and writes with credit counters. Read data returns through a RESP_DEPTH-entry FIFO, so the response path never stalls the DRAM controller. Sits between the MemoryBus arbiter and the DRAM controller's AXI3 slave port.

---
 rtl/dram_axi_bridge_if.sv | 32 +++
 rtl/dram_axi_bridge.sv | 228 ++++++++++++++++++++++
 tb/tb_dram_axi_bridge.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_axi_bridge_if.sv
// MemoryBus: request/response bus between the MemoryBus arbiter and a memory
// slave such as dram_axi_bridge.
//   Request  (master -> slave): msValid, msWrite, msAddress, msData, msID
//   Request  (slave -> master): msTaken
//   Response (slave -> master): smValid, smData, smID
//   Response (master -> slave): smTaken
interface MemoryBus #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 8
);
   logic                  msValid;
   logic                  msTaken;
   logic                  msWrite;
   logic [ADDR_WIDTH-1:0] msAddress;
   logic [DATA_WIDTH-1:0] msData;
   logic [ID_WIDTH-1:0]   msID;
   logic                  smValid;
   logic                  smTaken;
   logic [DATA_WIDTH-1:0] smData;
   logic [ID_WIDTH-1:0]   smID;

   modport Master (
      output msValid, msWrite, msAddress, msData, msID, smTaken,
      input  msTaken, smValid, smData, smID
   );

   modport Slave (
      input  msValid, msWrite, msAddress, msData, msID, smTaken,
      output msTaken, smValid, smData, smID
   );
endinterface

// File: rtl/dram_axi_bridge.sv
// dram_axi_bridge: MemoryBus slave to AXI3 master adapter for the DRAM
// controller. One request is held in an issue register and driven onto AW/W
// (writes) or AR (reads). Outstanding writes and reads are tracked with credit
// counters, and read data returns through a RESP_DEPTH-entry FIFO.
// Ports:
//   clock, reset           clock and asynchronous active-low reset
//   bus                    MemoryBus slave side (requests in, read data out)
//   aw*/w*/b*/ar*/r*       AXI3 master channels (single-beat, fixed attributes)
//   error                  sticky flag for nonzero bresp/rresp or spurious responses
//   idle                   no request held, nothing outstanding, FIFO empty
module dram_axi_bridge #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int ID_WIDTH     = 6,
   parameter int MAX_WRITES   = 4,
   parameter int RESP_DEPTH   = 4,
   parameter int BUS_ID_WIDTH = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   MemoryBus.Slave                 bus,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic [ID_WIDTH-1:0]     awid,
   output logic [1:0]              awburst,
   output logic [3:0]              awlen,
   output logic [2:0]              awsize,
   output logic [1:0]              awlock,
   output logic [3:0]              awcache,
   output logic [2:0]              awprot,
   output logic [3:0]              awqos,
   output logic                    wvalid,
   input  logic                    wready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [ID_WIDTH-1:0]     wid,
   output logic                    wlast,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    bvalid,
   output logic                    bready,
   input  logic [ID_WIDTH-1:0]     bid,
   input  logic [1:0]              bresp,
   output logic                    arvalid,
   input  logic                    arready,
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic [ID_WIDTH-1:0]     arid,
   output logic [1:0]              arburst,
   output logic [3:0]              arlen,
   output logic [2:0]              arsize,
   output logic [1:0]              arlock,
   output logic [3:0]              arcache,
   output logic [2:0]              arprot,
   output logic [3:0]              arqos,
   input  logic                    rvalid,
   output logic                    rready,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [ID_WIDTH-1:0]     rid,
   input  logic [1:0]              rresp,
   input  logic                    rlast,
   output logic                    error,
   output logic                    idle
);
   localparam int WCW = $clog2(MAX_WRITES) + 1;
   localparam int RCW = $clog2(RESP_DEPTH) + 1;
   localparam int PW  = $clog2(RESP_DEPTH);

   typedef enum logic [1:0] {EMPTY, WR_PEND, RD_PEND} issue_state_t;

   issue_state_t          state;
   logic                  aw_done;
   logic                  w_done;
   logic [ADDR_WIDTH-1:0] issue_addr;
   logic [DATA_WIDTH-1:0] issue_data;
   logic [ID_WIDTH-1:0]   issue_id;
   logic [WCW-1:0]        wr_out;
   logic [RCW-1:0]        rd_out;
   logic [RCW-1:0]        fifo_count;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [DATA_WIDTH-1:0] fifo_data [RESP_DEPTH];
   logic [ID_WIDTH-1:0]   fifo_id [RESP_DEPTH];

   logic aw_hs, w_hs, wr_complete, rd_complete, completing;
   logic wr_credit, rd_credit, ms_taken;
   logic b_spurious, r_spurious, push, pop;
   logic unused_inputs;

   // Fixed single-beat AXI3 attributes: INCR-free fixed burst, normal access,
   // bufferable/modifiable cache, full-width transfers.
   assign awburst = 2'd0;
   assign awlen   = 4'd0;
   assign awsize  = 3'($clog2(DATA_WIDTH/8));
   assign awlock  = 2'd0;
   assign awcache = 4'd3;
   assign awprot  = 3'd0;
   assign awqos   = 4'd0;
   assign arburst = 2'd0;
   assign arlen   = 4'd0;
   assign arsize  = 3'($clog2(DATA_WIDTH/8));
   assign arlock  = 2'd0;
   assign arcache = 4'd3;
   assign arprot  = 3'd0;
   assign arqos   = 4'd0;
   assign wstrb   = '1;
   assign bready  = 1'b1;
   assign rready  = 1'b1;

   assign awvalid = (state == WR_PEND) && !aw_done;
   assign wvalid  = (state == WR_PEND) && !w_done;
   assign wlast   = wvalid;
   assign arvalid = (state == RD_PEND);
   assign awaddr  = issue_addr;
   assign araddr  = issue_addr;
   assign awid    = issue_id;
   assign arid    = issue_id;
   assign wid     = issue_id;
   assign wdata   = issue_data;

   // A write completes once both halves are done, including handshakes
   // happening right now, so AW and W may finish in either order.
   assign aw_hs       = awvalid && awready;
   assign w_hs        = wvalid && wready;
   assign wr_complete = (state == WR_PEND) && (aw_done || aw_hs) && (w_done || w_hs);
   assign rd_complete = (state == RD_PEND) && arready;
   assign completing  = wr_complete || rd_complete;

   // Credits count the request sitting in the issue register, so a read can
   // never be issued without a FIFO slot waiting for its data.
   assign wr_credit = (int'(wr_out) + int'(state == WR_PEND)) < MAX_WRITES;
   assign rd_credit = (int'(rd_out) + int'(fifo_count) + int'(state == RD_PEND)) < RESP_DEPTH;
   assign ms_taken  = bus.msValid && (bus.msWrite ? wr_credit : rd_credit) &&
                      ((state == EMPTY) || completing);
   assign bus.msTaken = ms_taken;

   assign b_spurious = bvalid && !wr_complete && (wr_out == '0);
   assign r_spurious = rvalid && !rd_complete && (rd_out == '0);

   assign push        = rvalid && (fifo_count != RCW'(RESP_DEPTH));
   assign pop         = bus.smValid && bus.smTaken;
   assign bus.smValid = (fifo_count != '0);
   assign bus.smData  = fifo_data[rd_ptr];
   assign bus.smID    = BUS_ID_WIDTH'(fifo_id[rd_ptr]);

   assign idle = (state == EMPTY) && (wr_out == '0) && (rd_out == '0) && (fifo_count == '0);

   assign unused_inputs = &{1'b0, rlast, bid, bus.msID};

   // Issue register: a new request may be loaded in the same cycle the
   // current one completes, giving one request per cycle back to back.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= EMPTY;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         issue_addr <= '0;
         issue_data <= '0;
         issue_id   <= '0;
      end else begin
         if (wr_complete) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
         end
         if (ms_taken) begin
            state      <= bus.msWrite ? WR_PEND : RD_PEND;
            issue_addr <= bus.msAddress;
            issue_data <= bus.msData;
            issue_id   <= bus.msID[ID_WIDTH-1:0];
         end else if (completing) begin
            state <= EMPTY;
         end
      end
   end

   // Outstanding-transaction counters; a response arriving at zero is
   // ignored and flagged rather than wrapping the counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_out <= '0;
         rd_out <= '0;
      end else begin
         if (wr_complete && !bvalid)
            wr_out <= wr_out + WCW'(1);
         else if (bvalid && !wr_complete && (wr_out != '0))
            wr_out <= wr_out - WCW'(1);
         if (rd_complete && !rvalid)
            rd_out <= rd_out + RCW'(1);
         else if (rvalid && !rd_complete && (rd_out != '0))
            rd_out <= rd_out - RCW'(1);
      end
   end

   // Read-response FIFO pointers and occupancy; pointers wrap naturally
   // because the depth is a power of two.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            fifo_count <= fifo_count + RCW'(1);
         else if (pop && !push)
            fifo_count <= fifo_count - RCW'(1);
      end
   end

   // FIFO storage needs no reset; occupancy alone says what is valid.
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_data[wr_ptr] <= rdata;
         fifo_id[wr_ptr]   <= rid;
      end
   end

   // Sticky error flag for bad responses and responses nobody asked for.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         error <= 1'b0;
      else if ((bvalid && (bresp != 2'd0)) || (rvalid && (rresp != 2'd0)) ||
               b_spurious || r_spurious)
         error <= 1'b1;
   end
endmodule

// File: tb/tb_dram_axi_bridge.sv
// tb_dram_axi_bridge: self-checking bench for dram_axi_bridge. Each scenario
// task drives the MemoryBus and AXI slave side; expected write beats, AR
// requests and read responses are queued when stimulus is driven and popped
// when the bridge presents them.
module tb_dram_axi_bridge;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   MemoryBus #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(8)) bus ();

   logic        awvalid, awready;
   logic [31:0] awaddr;
   logic [5:0]  awid;
   logic [1:0]  awburst, awlock, arburst, arlock;
   logic [3:0]  awlen, awcache, awqos, arlen, arcache, arqos;
   logic [2:0]  awsize, awprot, arsize, arprot;
   logic        wvalid, wready, wlast;
   logic [31:0] wdata;
   logic [5:0]  wid;
   logic [3:0]  wstrb;
   logic        bvalid, bready;
   logic [5:0]  bid;
   logic [1:0]  bresp;
   logic        arvalid, arready;
   logic [31:0] araddr;
   logic [5:0]  arid;
   logic        rvalid, rready, rlast;
   logic [31:0] rdata;
   logic [5:0]  rid;
   logic [1:0]  rresp;
   logic        error, idle;

   int tests_run = 0;
   int tests_failed = 0;

   logic [37:0] w_q [$];
   logic [37:0] ar_q [$];
   logic [39:0] rd_q [$];
   logic [37:0] exp38;
   logic [39:0] exp40;

   dram_axi_bridge dut (
      .clock(clock), .reset(reset), .bus(bus),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
      .awburst(awburst), .awlen(awlen), .awsize(awsize), .awlock(awlock),
      .awcache(awcache), .awprot(awprot), .awqos(awqos),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wid(wid), .wlast(wlast), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
      .arburst(arburst), .arlen(arlen), .arsize(arsize), .arlock(arlock),
      .arcache(arcache), .arprot(arprot), .arqos(arqos),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
      .error(error), .idle(idle)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic offer(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic [7:0] id);
      bus.msValid = 1'b1; bus.msWrite = wr; bus.msAddress = addr; bus.msData = data; bus.msID = id;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock) reset = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      tests_run++; if (awvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_awvalid: got %b want 0", awvalid); end
      tests_run++; if (wvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wvalid: got %b want 0", wvalid); end
      tests_run++; if (arvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_arvalid: got %b want 0", arvalid); end
      tests_run++; if (bus.smValid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_smValid: got %b want 0", bus.smValid); end
      @(negedge clock) reset = 1'b1;
      tick();
      tests_run++; if (error !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_error: got %b want 0", error); end
      tests_run++; if (idle !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_idle: got %b want 1", idle); end
      tests_run++; if ({bready, rready} !== 2'b11) begin tests_failed++; $display("[TB] FAIL reset_readies: got %b want 11", {bready, rready}); end
      tests_run++; if ({awsize, awcache, awburst, awlen} !== {3'd2, 4'd3, 2'd0, 4'd0}) begin tests_failed++; $display("[TB] FAIL aw_attrs: got %h", {awsize, awcache, awburst, awlen}); end
      tests_run++; if ({arsize, arcache, arlock, arprot} !== {3'd2, 4'd3, 2'd0, 3'd0}) begin tests_failed++; $display("[TB] FAIL ar_attrs: got %h", {arsize, arcache, arlock, arprot}); end
      tests_run++; if (wstrb !== 4'hF) begin tests_failed++; $display("[TB] FAIL wstrb: got %h want f", wstrb); end
   endtask

   task automatic test_write_aw_first();
      awready = 1'b1; wready = 1'b0; bvalid = 1'b0;
      offer(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 8'hC5);
      #1;
      tests_run++; if (bus.msTaken !== 1'b1) begin tests_failed++; $display("[TB] FAIL awf_taken: got %b want 1", bus.msTaken); end
      w_q.push_back({6'h05, 32'hDEAD_BEEF});
      tick();
      bus.msValid = 1'b0;
      tests_run++; if ({awvalid, wvalid} !== 2'b11) begin tests_failed++; $display("[TB] FAIL awf_valids: got %b want 11", {awvalid, wvalid}); end
      tests_run++; if ({awid, awaddr} !== {6'h05, 32'h0000_0100}) begin tests_failed++; $display("[TB] FAIL awf_aw: got %h", {awid, awaddr}); end
      tick();
      tests_run++; if ({awvalid, wvalid} !== 2'b01) begin tests_failed++; $display("[TB] FAIL awf_aw_drop: got %b want 01", {awvalid, wvalid}); end
      tick();
      tests_run++; if (wvalid !== 1'b1) begin tests_failed++; $display("[TB] FAIL awf_w_hold: got %b want 1", wvalid); end
      wready = 1'b1;
      #1;
      tests_run++; if (wlast !== 1'b1) begin tests_failed++; $display("[TB] FAIL awf_wlast: got %b want 1", wlast); end
      if (w_q.size() == 0) begin tests_run++; tests_failed++; $display("[TB] FAIL awf_wq: queue empty"); end
      else begin exp38 = w_q.pop_front(); tests_run++; if ({wid, wdata} !== exp38) begin tests_failed++; $display("[TB] FAIL awf_wbeat: got %h want %h", {wid, wdata}, exp38); end end
      tick();
      wready = 1'b0;
      tests_run++; if ({wvalid, idle} !== 2'b00) begin tests_failed++; $display("[TB] FAIL awf_done: got wvalid/idle %b want 00", {wvalid, idle}); end
      bvalid = 1'b1; bresp = 2'd0; bid = 6'h05;
      tick();
      bvalid = 1'b0;
      tests_run++; if ({idle, error} !== 2'b10) begin tests_failed++; $display("[TB] FAIL awf_bresp: got idle/error %b want 10", {idle, error}); end
   endtask

   task automatic test_write_w_first();
      awready = 1'b0; wready = 1'b1;
      offer(1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 8'h7A);
      #1;
      if (bus.msTaken) w_q.push_back({6'h3A, 32'hDEAD_BEEF});
      tick();
      bus.msValid = 1'b0;
      if (w_q.size() == 0) begin tests_run++; tests_failed++; $display("[TB] FAIL wf_wq: queue empty"); end
      else begin exp38 = w_q.pop_front(); tests_run++; if ({wid, wdata} !== exp38) begin tests_failed++; $display("[TB] FAIL wf_wbeat: got %h want %h", {wid, wdata}, exp38); end end
      tick();
      tests_run++; if ({awvalid, wvalid, awaddr} !== {2'b10, 32'h0000_0200}) begin tests_failed++; $display("[TB] FAIL wf_aw_wait: got %h", {awvalid, wvalid, awaddr}); end
      awready = 1'b1;
      tick();
      tests_run++; if ({awvalid, idle} !== 2'b00) begin tests_failed++; $display("[TB] FAIL wf_done: got awvalid/idle %b want 00", {awvalid, idle}); end
      offer(1'b1, 32'h0000_0300, 32'h1234_5678, 8'h41);
      #1;
      if (bus.msTaken) w_q.push_back({6'h01, 32'h1234_5678});
      tick();
      bus.msValid = 1'b0;
      tests_run++; if ({awvalid, wvalid} !== 2'b11) begin tests_failed++; $display("[TB] FAIL sim_valids: got %b want 11", {awvalid, wvalid}); end
      if (w_q.size() == 0) begin tests_run++; tests_failed++; $display("[TB] FAIL sim_wq: queue empty"); end
      else begin exp38 = w_q.pop_front(); tests_run++; if ({wid, wdata} !== exp38) begin tests_failed++; $display("[TB] FAIL sim_wbeat: got %h want %h", {wid, wdata}, exp38); end end
      tick();
      tests_run++; if ({awvalid, wvalid} !== 2'b00) begin tests_failed++; $display("[TB] FAIL sim_drop: got %b want 00", {awvalid, wvalid}); end
      bvalid = 1'b1; tick(); bvalid = 1'b0;
      tests_run++; if (idle !== 1'b0) begin tests_failed++; $display("[TB] FAIL two_writes_one_left: got idle %b want 0", idle); end
      bvalid = 1'b1; tick(); bvalid = 1'b0;
      tests_run++; if ({idle, error} !== 2'b10) begin tests_failed++; $display("[TB] FAIL two_writes_done: got idle/error %b want 10", {idle, error}); end
   endtask

   task automatic test_read_credit();
      bus.smTaken = 1'b0; arready = 1'b1; awready = 1'b0; wready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         offer(1'b0, 32'h0000_1000 + 32'(i * 4), 32'h0, 8'h10 + 8'(i));
         #1;
         if (arvalid) begin
            if (ar_q.size() == 0) begin tests_run++; tests_failed++; $display("[TB] FAIL rc_arq: unexpected AR %h", {arid, araddr}); end
            else begin exp38 = ar_q.pop_front(); tests_run++; if ({arid, araddr} !== exp38) begin tests_failed++; $display("[TB] FAIL rc_ar: got %h want %h", {arid, araddr}, exp38); end end
         end
         tests_run++; if (bus.msTaken !== (i < 4)) begin tests_failed++; $display("[TB] FAIL rc_taken_%0d: got %b want %b", i, bus.msTaken, (i < 4)); end
         if (bus.msTaken) ar_q.push_back({6'h10 + 6'(i), 32'h0000_1000 + 32'(i * 4)});
         tick();
      end
      bus.msValid = 1'b0;
      tests_run++; if ({arvalid, 32'(ar_q.size())} !== 33'd0) begin tests_failed++; $display("[TB] FAIL rc_ar_left: arvalid %b queue %0d", arvalid, ar_q.size()); end
      for (int i = 0; i < 4; i++) begin
         rvalid = 1'b1; rresp = 2'd0; rlast = 1'b1; rid = 6'h10 + 6'(i); rdata = 32'hA000_0000 + 32'(i);
         rd_q.push_back({2'b00, rid, rdata});
         tick();
         if (i == 0) begin tests_run++; if (bus.smValid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rc_latency: smValid %b want 1", bus.smValid); end end
      end
      rvalid = 1'b0;
      offer(1'b0, 32'h0000_1100, 32'h0, 8'h1F);
      #1;
      tests_run++; if (bus.msTaken !== 1'b0) begin tests_failed++; $display("[TB] FAIL rc_full_taken: got %b want 0", bus.msTaken); end
      bus.msValid = 1'b0;
      bus.smTaken = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tests_run++; if (bus.smValid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rc_drain_valid_%0d: got %b want 1", i, bus.smValid); end
         if (rd_q.size() == 0) begin tests_run++; tests_failed++; $display("[TB] FAIL rc_rdq: queue empty"); end
         else begin exp40 = rd_q.pop_front(); tests_run++; if ({bus.smID, bus.smData} !== exp40) begin tests_failed++; $display("[TB] FAIL rc_drain_%0d: got %h want %h", i, {bus.smID, bus.smData}, exp40); end end
         tick();
      end
      bus.smTaken = 1'b0;
      tests_run++; if ({bus.smValid, idle} !== 2'b01) begin tests_failed++; $display("[TB] FAIL rc_empty: got smValid/idle %b want 01", {bus.smValid, idle}); end
   endtask

   task automatic test_write_limit();
      bvalid = 1'b0; awready = 1'b1; wready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         offer(1'b1, 32'h0000_4000 + 32'(i * 4), 32'h5000_0000 + 32'(i), 8'h20 + 8'(i));
         #1;
         if (wvalid) begin
            if (w_q.size() == 0) begin tests_run++; tests_failed++; $display("[TB] FAIL wl_wq: unexpected beat %h", {wid, wdata}); end
            else begin exp38 = w_q.pop_front(); tests_run++; if ({wid, wdata} !== exp38) begin tests_failed++; $display("[TB] FAIL wl_wbeat: got %h want %h", {wid, wdata}, exp38); end end
         end
         tests_run++; if (bus.msTaken !== (i < 4)) begin tests_failed++; $display("[TB] FAIL wl_taken_%0d: got %b want %b", i, bus.msTaken, (i < 4)); end
         if (bus.msTaken) w_q.push_back({6'h20 + 6'(i), 32'h5000_0000 + 32'(i)});
         tick();
      end
      bvalid = 1'b1; bresp = 2'd0;
      #1;
      tests_run++; if (bus.msTaken !== 1'b0) begin tests_failed++; $display("[TB] FAIL wl_taken_during_b: got %b want 0", bus.msTaken); end
      tick();
      bvalid = 1'b0;
      #1;
      tests_run++; if (bus.msTaken !== 1'b1) begin tests_failed++; $display("[TB] FAIL wl_slot_freed: got %b want 1", bus.msTaken); end
      if (bus.msTaken) w_q.push_back({6'h25, 32'h5000_0005});
      tick();
      bus.msValid = 1'b0;
      if (w_q.size() == 0) begin tests_run++; tests_failed++; $display("[TB] FAIL wl_wq_last: queue empty"); end
      else begin exp38 = w_q.pop_front(); tests_run++; if ({wvalid, wid, wdata} !== {1'b1, exp38}) begin tests_failed++; $display("[TB] FAIL wl_last_beat: got %h want %h", {wvalid, wid, wdata}, {1'b1, exp38}); end end
      tick();
      bvalid = 1'b1;
      repeat (3) tick();
      tests_run++; if (idle !== 1'b0) begin tests_failed++; $display("[TB] FAIL wl_one_left: got idle %b want 0", idle); end
      tick();
      bvalid = 1'b0;
      tests_run++; if ({idle, error} !== 2'b10) begin tests_failed++; $display("[TB] FAIL wl_all_done: got idle/error %b want 10", {idle, error}); end
   endtask

   task automatic test_error();
      arready = 1'b1; bus.smTaken = 1'b0;
      offer(1'b0, 32'h0000_2000, 32'h0, 8'h21);
      tick(); bus.msValid = 1'b0; tick();
      rvalid = 1'b1; rresp = 2'd2; rid = 6'h21; rdata = 32'hBAD0_BAD0;
      rd_q.push_back({2'b00, 6'h21, 32'hBAD0_BAD0});
      tick();
      rvalid = 1'b0; rresp = 2'd0;
      tests_run++; if ({error, bus.smValid} !== 2'b11) begin tests_failed++; $display("[TB] FAIL err_rresp: got error/smValid %b want 11", {error, bus.smValid}); end
      bus.smTaken = 1'b1;
      exp40 = rd_q.pop_front();
      tests_run++; if ({bus.smID, bus.smData} !== exp40) begin tests_failed++; $display("[TB] FAIL err_data: got %h want %h", {bus.smID, bus.smData}, exp40); end
      tick();
      bus.smTaken = 1'b0;
      offer(1'b0, 32'h0000_2004, 32'h0, 8'h22);
      tick(); bus.msValid = 1'b0; tick();
      rvalid = 1'b1; rresp = 2'd0; rid = 6'h22; rdata = 32'h600D_F00D;
      rd_q.push_back({2'b00, 6'h22, 32'h600D_F00D});
      tick();
      rvalid = 1'b0;
      bus.smTaken = 1'b1;
      exp40 = rd_q.pop_front();
      tests_run++; if ({bus.smValid, bus.smID, bus.smData} !== {1'b1, exp40}) begin tests_failed++; $display("[TB] FAIL err_good_data: got %h want %h", {bus.smValid, bus.smID, bus.smData}, {1'b1, exp40}); end
      tick();
      bus.smTaken = 1'b0;
      tests_run++; if ({error, idle} !== 2'b11) begin tests_failed++; $display("[TB] FAIL err_sticky: got error/idle %b want 11", {error, idle}); end
      pulse_reset();
      tests_run++; if (error !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_cleared: got %b want 0", error); end
      bvalid = 1'b1; bresp = 2'd0;
      tick();
      bvalid = 1'b0;
      tests_run++; if ({error, idle} !== 2'b11) begin tests_failed++; $display("[TB] FAIL err_spurious_b: got error/idle %b want 11", {error, idle}); end
   endtask

   task automatic test_reset_mid();
      pulse_reset();
      arready = 1'b1; bus.smTaken = 1'b0;
      for (int i = 0; i < 2; i++) begin
         offer(1'b0, 32'h0000_3000 + 32'(i * 4), 32'h0, 8'h30 + 8'(i));
         tick();
      end
      bus.msValid = 1'b0;
      tick();
      for (int i = 0; i < 2; i++) begin
         rvalid = 1'b1; rresp = 2'd0; rid = 6'h30 + 6'(i); rdata = 32'hC000_0000 + 32'(i);
         tick();
      end
      rvalid = 1'b0;
      awready = 1'b0; wready = 1'b0;
      offer(1'b1, 32'h0000_5000, 32'h7777_7777, 8'h05);
      tick();
      bus.msValid = 1'b0;
      tests_run++; if ({bus.smValid, awvalid, wvalid, idle} !== 4'b1110) begin tests_failed++; $display("[TB] FAIL rm_before: got %b want 1110", {bus.smValid, awvalid, wvalid, idle}); end
      #2 reset = 1'b0;
      #1;
      tests_run++; if ({bus.smValid, awvalid, wvalid} !== 3'b000) begin tests_failed++; $display("[TB] FAIL rm_async: got %b want 000", {bus.smValid, awvalid, wvalid}); end
      @(negedge clock) reset = 1'b1;
      tick();
      tests_run++; if ({idle, bus.smValid, awvalid, wvalid, error} !== 5'b10000) begin tests_failed++; $display("[TB] FAIL rm_after: got %b want 10000", {idle, bus.smValid, awvalid, wvalid, error}); end
   endtask

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b0;
      bus.msValid = 1'b0; bus.msWrite = 1'b0; bus.msAddress = '0; bus.msData = '0; bus.msID = '0; bus.smTaken = 1'b0;
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      bvalid = 1'b0; bid = '0; bresp = '0;
      rvalid = 1'b0; rdata = '0; rid = '0; rresp = '0; rlast = 1'b0;
      test_reset();
      test_write_aw_first();
      test_write_w_first();
      test_read_credit();
      test_write_limit();
      test_error();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
